recv_block: RTL and testbench

RECV_BLOCK -- requirements
Module: recv_block

---
 rtl/recv_block.sv | 204 ++++++++++++++++++++
 tb/tb_recv_block.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/recv_block.sv
// recv_block: oversampled serial byte receiver (start, 8 data LSB first, stop) feeding a
// first-word fall-through byte FIFO. Define RECV_BLOCK_PARITY_EN for an even-parity bit and parity_err.
module recv_block #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DEPTH      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inbit,
  input  logic       read,
  input  logic       err_clr,
  output logic [7:0] dataout,
  output logic       empty,
  output logic       full,
  output logic [3:0] count,
  output logic       frame_err,
`ifdef RECV_BLOCK_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MID    = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST   = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT
`ifdef RECV_BLOCK_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync2_q;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               empty_q, empty_d, full_q, full_d;
  logic               frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic [7:0]         mem_q [DEPTH];

  logic rx, mid, push, pop, frame_set, overrun_set;
`ifdef RECV_BLOCK_PARITY_EN
  logic par_bad_q, par_bad_d, parity_err_q, parity_err_d, par_set;
`endif

  assign rx  = sync2_q;
  assign mid = (tick_q == TICK_W'(MID));
  assign pop = read & ~empty_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Receive FSM and FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    tick_d      = (tick_q == TICK_W'(LAST)) ? '0 : tick_q + TICK_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
`ifdef RECV_BLOCK_PARITY_EN
    par_bad_d   = par_bad_q;
    par_set     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (!rx) state_d = S_START;
      end
      S_START: begin
        if (mid) begin
          if (!rx) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_d   = {rx, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef RECV_BLOCK_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef RECV_BLOCK_PARITY_EN
      S_PARITY: begin
        if (mid) begin
          par_bad_d = ^{shift_q, rx};
          par_set   = ^{shift_q, rx};
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (mid) begin
          if (rx) begin
            state_d = S_IDLE;
`ifdef RECV_BLOCK_PARITY_EN
            if (!par_bad_q) begin
`else
            begin
`endif
              if (!full_q || pop) push = 1'b1;
              else                overrun_set = 1'b1;
            end
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        tick_d = '0;
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    empty_d     = (count_d == '0);
    full_d      = (count_d == CNT_W'(DEPTH));
    // Set beats clear when both land in the same cycle.
    frame_err_d = (frame_err_q & ~err_clr) | frame_set;
    overrun_d   = (overrun_q & ~err_clr) | overrun_set;
`ifdef RECV_BLOCK_PARITY_EN
    parity_err_d = (parity_err_q & ~err_clr) | par_set;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      tick_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef RECV_BLOCK_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= inbit;
      sync2_q     <= sync1_q;
      tick_q      <= tick_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef RECV_BLOCK_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Storage is deliberately unreset; it is only visible when non-empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign dataout   = mem_q[rd_ptr_q];
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef RECV_BLOCK_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_recv_block.sv
// Directed self-checking bench for recv_block (default build, 10-bit frames, OVERSAMPLE=16, DEPTH=10).
module tb_recv_block;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inbit = 1'b1;
  logic       read = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dataout;
  logic       empty, full, frame_err, overrun;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  recv_block #(.OVERSAMPLE(OVS), .DEPTH(10)) dut (
    .clk(clk), .reset(reset), .inbit(inbit), .read(read), .err_clr(err_clr),
    .dataout(dataout), .empty(empty), .full(full), .count(count),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at the current negedge; returns 160 negedges later.
  // Push of a good byte lands between negedge 154 and 155 of the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input bit chk_timing, input bit rd_at_push);
    logic [9:0] bits;
    int n;
    bits = {stop_b, d, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      inbit = bits[i];
      for (int k = 0; k < OVS; k++) begin
        @(negedge clk);
        n++;
        if (chk_timing && n == 154) check("empty_before_push", 8'(empty), 8'h01);
        if (chk_timing && n == 155) check("empty_after_push", 8'(empty), 8'h00);
        if (rd_at_push) read = (n == 154);
      end
    end
  endtask

  task automatic pulse_read();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    repeat (3) @(negedge clk);
    check("rst_empty", 8'(empty), 8'h01);
    check("rst_full", 8'(full), 8'h00);
    check("rst_count", 8'(count), 8'h00);
    check("rst_frame_err", 8'(frame_err), 8'h00);
    check("rst_overrun", 8'(overrun), 8'h00);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Single good frame and pop.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check("a5_data", dataout, 8'hA5);
    check("a5_count", 8'(count), 8'h01);
    pulse_read();
    check("a5_pop_empty", 8'(empty), 8'h01);
    check("a5_pop_count", 8'(count), 8'h00);
    pulse_read();
    check("underflow_count", 8'(count), 8'h00);

    // Short low glitch is ignored.
    inbit = 1'b0;
    repeat (4) @(negedge clk);
    inbit = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_count", 8'(count), 8'h00);
    check("glitch_frame_err", 8'(frame_err), 8'h00);
    check("glitch_overrun", 8'(overrun), 8'h00);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    check("post_glitch_data", dataout, 8'h5A);
    pulse_read();

    // Framing error with line held low afterwards.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (50 - OVS) @(negedge clk);
    check("ferr_flag", 8'(frame_err), 8'h01);
    check("ferr_count", 8'(count), 8'h00);
    inbit = 1'b1;
    repeat (40) @(negedge clk);
    check("ferr_no_restart", 8'(count), 8'h00);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    check("ferr_recover_data", dataout, 8'h81);
    check("ferr_recover_count", 8'(count), 8'h01);
    pulse_clr();
    check("ferr_clr", 8'(frame_err), 8'h00);
    pulse_read();

    // Eleven back-to-back frames overflow a 10-entry FIFO.
    for (int i = 0; i < 11; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    check("ovr_full", 8'(full), 8'h01);
    check("ovr_count", 8'(count), 8'h0A);
    check("ovr_flag", 8'(overrun), 8'h01);
    for (int i = 0; i < 10; i++) begin
      check("ovr_read_data", dataout, 8'(i));
      pulse_read();
    end
    check("ovr_drained", 8'(empty), 8'h01);
    pulse_clr();
    check("ovr_clr", 8'(overrun), 8'h00);

    // Full FIFO with a read coinciding with the push.
    for (int i = 0; i < 10; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
    check("sim_full_pre", 8'(full), 8'h01);
    send_frame(8'h77, 1'b1, 1'b0, 1'b1);
    check("sim_count", 8'(count), 8'h0A);
    check("sim_overrun", 8'(overrun), 8'h00);
    check("sim_full", 8'(full), 8'h01);
    for (int i = 0; i < 10; i++) begin
      v = (i == 9) ? 8'h77 : 8'h21 + 8'(i);
      check("sim_read_data", dataout, v);
      pulse_read();
    end
    check("sim_drained", 8'(empty), 8'h01);

    // Reset in the middle of data bit 4 of 0xFF discards FIFO and frame.
    send_frame(8'h99, 1'b1, 1'b0, 1'b0);
    check("pre_rst_count", 8'(count), 8'h01);
    inbit = 1'b0;
    repeat (OVS) @(negedge clk);
    inbit = 1'b1;
    repeat (OVS * 4 + 8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_empty", 8'(empty), 8'h01);
    check("midrst_count", 8'(count), 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (120) @(negedge clk);
    check("postrst_count", 8'(count), 8'h00);
    check("postrst_frame_err", 8'(frame_err), 8'h00);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    check("postrst_data", dataout, 8'h12);
    check("postrst_count1", 8'(count), 8'h01);
    pulse_read();
    check("postrst_empty", 8'(empty), 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
